// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Boot-time program loader. Receives a byte stream over a valid/ready
// handshake, assembles little-endian 32-bit instruction words and writes them
// to consecutive word addresses of the instruction RAM, starting at 0. The
// core is held in reset until the declared number of words has been written.
//
// Stream format: 16-bit length N (low byte first), then N words of 4 bytes,
// least-significant byte first.
//
// Parameters:
//   ADDR_W     word-address width of the instruction RAM
//   MAX_WORDS  largest accepted program length in words (<= 2**ADDR_W)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   start       single-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid  byte_data is valid this cycle
//   byte_data   incoming stream byte
//   byte_ready  loader accepts a byte this cycle (LEN0, LEN1, DATA)
//   mem_we      instruction RAM write enable, one cycle per word
//   mem_addr    byte address of the word being written
//   mem_wdata   assembled instruction word
//   cpu_hold    holds the core in reset; low only after a successful load
//   busy        a load is in progress
//   done        the load completed successfully
//   error       the declared length exceeded MAX_WORDS
//   word_count  words written in the current or last load
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

  state_e            state_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_idx_q;
  logic [31:0]       word_q;
  logic [ADDR_W:0]   word_count_q;

  logic              take;
  logic [15:0]       len_d;
  logic [ADDR_W:0]   word_count_d;

  // A byte moves only in the byte-accepting states; byte_ready depends on
  // state alone, so there is no input-to-output combinational path.
  assign byte_ready   = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
  assign take         = byte_valid && byte_ready;
  // Full length as it will be once the high byte in LEN1 is captured.
  assign len_d        = {byte_data, len_q[7:0]};
  assign word_count_d = word_count_q + 1'b1;

  // All outputs are decoded from registered state.
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = 32'({word_count_q, 2'b00});
  assign mem_wdata  = word_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign busy       = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign word_count = word_count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      word_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN0;
            byte_idx_q   <= '0;
            word_count_q <= '0;
          end
        end

        S_LEN0: begin
          if (take) begin
            len_q[7:0] <= byte_data;
            state_q    <= S_LEN1;
          end
        end

        S_LEN1: begin
          if (take) begin
            len_q[15:8] <= byte_data;
            if (len_d == 16'd0)        state_q <= S_DONE;
            else if (len_d > MAX_LEN)  state_q <= S_ERR;
            else                       state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (take) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) state_q <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The write happens during this cycle; the count advances after it.
          word_count_q <= word_count_d;
          if (16'(word_count_d) == len_q) state_q <= S_DONE;
          else                            state_q <= S_DATA;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
